// File: rtl/usb_fifo_bank_if.sv
// Bus bundle for usb_fifo_bank: write port, read port, per-channel flush and
// the per-channel status vectors. The master side is the writer/reader, the
// slave side is the FIFO bank itself.
interface usb_fifo_bank_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int N_CH   = 4
);
    localparam int CW = $clog2(N_CH);
    localparam int NW = $clog2(DEPTH + 1);

    logic                 w_enable;
    logic [CW-1:0]        w_ch;
    logic [DATA_W-1:0]    w_data;
    logic                 w_last;
    logic                 r_enable;
    logic [CW-1:0]        r_ch;
    logic [DATA_W-1:0]    r_data;
    logic                 r_last;
    logic [N_CH-1:0]      flush;
    logic [N_CH-1:0]      empty;
    logic [N_CH-1:0]      full;
    logic [N_CH-1:0]      pkt_avail;
    logic [N_CH*NW-1:0]   count;
    logic [N_CH-1:0]      overflow;
    logic [N_CH-1:0]      underflow;

    modport master (
        output w_enable, w_ch, w_data, w_last,
        output r_enable, r_ch, flush,
        input  r_data, r_last, empty, full, pkt_avail, count,
        input  overflow, underflow
    );

    modport slave (
        input  w_enable, w_ch, w_data, w_last,
        input  r_enable, r_ch, flush,
        output r_data, r_last, empty, full, pkt_avail, count,
        output overflow, underflow
    );
endinterface

// File: rtl/usb_fifo_bank.sv
// Bank of N_CH independent fall-through byte FIFOs. Each word carries a
// packet-end tag; each channel keeps an occupancy count, a count of complete
// packets held, and sticky overflow/underflow flags cleared by flush or reset.
module usb_fifo_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int N_CH   = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_fifo_bank_if.slave    bus
);
    localparam int CW = $clog2(N_CH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W:0]   mem     [N_CH][DEPTH];
    logic [PW-1:0]     wr_ptr  [N_CH];
    logic [PW-1:0]     rd_ptr  [N_CH];
    logic [NW-1:0]     cnt     [N_CH];
    logic [NW-1:0]     pkt     [N_CH];
    logic [NW-1:0]     cnt_nxt [N_CH];
    logic [NW-1:0]     pkt_nxt [N_CH];
    logic [N_CH-1:0]   ovf;
    logic [N_CH-1:0]   udf;

    logic [N_CH-1:0]   wr_sel;
    logic [N_CH-1:0]   rd_sel;
    logic [N_CH-1:0]   is_empty;
    logic [N_CH-1:0]   is_full;
    logic [N_CH-1:0]   push_ok;
    logic [N_CH-1:0]   pop_ok;
    logic [N_CH-1:0]   pop_last;
    logic [N_CH-1:0]   ovf_set;
    logic [N_CH-1:0]   udf_set;

    // Per-channel accept/reject decisions and next counter values.
    // A push into a full channel is still accepted when the same channel is
    // popped this cycle; a pop of an empty channel is never accepted, even
    // if a push lands in the same cycle (no bypass).
    always_comb begin
        wr_sel   = '0;
        rd_sel   = '0;
        is_empty = '0;
        is_full  = '0;
        push_ok  = '0;
        pop_ok   = '0;
        pop_last = '0;
        ovf_set  = '0;
        udf_set  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i]  = cnt[i];
            pkt_nxt[i]  = pkt[i];
            wr_sel[i]   = bus.w_enable && (bus.w_ch == CW'(i));
            rd_sel[i]   = bus.r_enable && (bus.r_ch == CW'(i));
            is_empty[i] = (cnt[i] == '0);
            is_full[i]  = (cnt[i] == NW'(DEPTH));
            pop_ok[i]   = rd_sel[i] && !is_empty[i];
            push_ok[i]  = wr_sel[i] && (!is_full[i] || pop_ok[i]);
            pop_last[i] = mem[i][rd_ptr[i]][DATA_W];
            ovf_set[i]  = wr_sel[i] && is_full[i] && !pop_ok[i];
            udf_set[i]  = rd_sel[i] && is_empty[i];
            cnt_nxt[i]  = cnt[i] + NW'(push_ok[i]) - NW'(pop_ok[i]);
            pkt_nxt[i]  = pkt[i] + NW'(push_ok[i] && bus.w_last)
                                 - NW'(pop_ok[i] && pop_last[i]);
        end
    end

    // Channel state: storage, pointers, counters and sticky flags; flush
    // takes priority over any access to its channel and keeps storage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                pkt[i]    <= '0;
            end
            ovf <= '0;
            udf <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.flush[i]) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    cnt[i]    <= '0;
                    pkt[i]    <= '0;
                    ovf[i]    <= 1'b0;
                    udf[i]    <= 1'b0;
                end else begin
                    if (push_ok[i]) begin
                        mem[i][wr_ptr[i]] <= {bus.w_last, bus.w_data};
                        wr_ptr[i]         <= wr_ptr[i] + PW'(1);
                    end
                    if (pop_ok[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + PW'(1);
                    end
                    cnt[i] <= cnt_nxt[i];
                    pkt[i] <= pkt_nxt[i];
                    if (ovf_set[i]) begin
                        ovf[i] <= 1'b1;
                    end
                    if (udf_set[i]) begin
                        udf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Fall-through head word of the selected read channel.
    assign {bus.r_last, bus.r_data} = mem[bus.r_ch][rd_ptr[bus.r_ch]];

    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;

    for (genvar g = 0; g < N_CH; g++) begin : g_status
        assign bus.count[g*NW +: NW] = cnt[g];
        assign bus.pkt_avail[g]      = (pkt[g] != '0);
    end
endmodule

// File: doc/usb_fifo_bank.md
# usb_fifo_bank

Parametrised bank of N_CH independent byte FIFOs with packet-boundary tagging, per-channel flush and sticky overflow/underflow flags. It sits between the receive path's PID/class decoder and the transmit control unit. It replaces the separate fixed-depth PID, non-data, padding and data FIFOs with a single block. The writer selects a channel per byte, and the reader selects a channel and sees its head word fall-through.

## Interface
- DATA_W, 8, width of each stored word
- DEPTH, 8, words per channel; power of two, ≥2
- N_CH, 4, number of channels; ≥2
- CW (local), $clog2(N_CH), channel-select width
- NW (local), $clog2(DEPTH+1), per-channel count width
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- w_enable  input  1  push w_data/w_last into channel w_ch
- w_ch  input  CW  write channel select
- w_data  input  DATA_W  write word
- w_last  input  1  marks final word of a packet
- r_enable  input  1  pop head of channel r_ch
- r_ch  input  CW  read channel select
- r_data  output  DATA_W  head word of channel r_ch (combinational)
- r_last  output  1  packet-end tag of that head word
- flush  input  N_CH  per-channel synchronous clear
- empty  output  N_CH  channel holds 0 words
- full  output  N_CH  channel holds DEPTH words
- pkt_avail  output  N_CH  channel holds ≥1 word tagged last
- count  output  N_CH*NW  per-channel occupancy; channel i in bits [i*NW +: NW]
- overflow  output  N_CH  sticky: write dropped on full channel
- underflow  output  N_CH  sticky: read attempted on empty channel

## Operation
- Each channel: DEPTH×(DATA_W+1) storage, wr_ptr and rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy counter of NW bits, and a packet counter of NW bits.
- Storage is reset to zero, so r_data = 0 and r_last = 0 after reset.
- Write: if w_enable and count[w_ch] < DEPTH, store {w_last, w_data} at wr_ptr, then increment wr_ptr. If the channel is full and there is no same-channel pop this cycle, drop the word and set overflow[w_ch].
- Read: r_data/r_last show mem[rd_ptr] of r_ch at all times; the value is undefined-but-stable when empty (last stored or zero). If r_enable and count[r_ch] > 0, increment rd_ptr. If the channel is empty, leave state unchanged and set underflow[r_ch].
- Same-channel read and write in one cycle:
  - Channel full: both succeed, count unchanged.
  - Channel empty: write succeeds, read is ignored and flags underflow; FWFT provides no bypass.
  - Otherwise: both succeed, count unchanged.
- Different channels: read and write proceed independently.
- Packet counter: increments on an accepted write with w_last = 1 and decrements on an accepted pop of a word with last = 1. An accepted write and pop in the same cycle both apply. pkt_avail[i] = (pkt count ≠ 0).
- flush[i]: the next edge zeroes wr_ptr, rd_ptr, count, pkt count, overflow[i] and underflow[i] for channel i. Flush overrides any read or write to channel i in that cycle, and sets no flags. Storage contents are not cleared.
- Sticky flags clear only by reset or flush.
- empty, full and pkt_avail are decoded from registered counters. There is no extra register stage.

## Timing
- Reset (n_rst low, asynchronous): all pointers, counters and flags go to 0. empty = all 1s, full = 0, pkt_avail = 0, count = 0, overflow = underflow = 0, r_data = 0, r_last = 0.
- Write latency: a word pushed at edge k appears on r_data at edge k (next cycle) if the channel was empty and r_ch selects it. empty deasserts after the same edge.
- Pop: r_data advances to the next word in the cycle after the r_enable edge.
- Flags and counts update on the same edge as the push or pop that causes them.
- Changing r_ch changes r_data/r_last combinationally in the same cycle.
- Reset asserted mid-packet discards all contents. After release, the first write lands at pointer 0.

## Test plan
- Reset, then write 0xA5 (last = 0) to ch 2 -> next cycle empty[2] = 0, count ch2 = 1, r_data = 0xA5 with r_ch = 2, other channels still empty.
- Fill ch 1 with 0x00..0x07 (DEPTH = 8), write 0xFF -> full[1] = 1, overflow[1] = 1, 0xFF dropped. Pop 8 -> data 0x00..0x07 in order, then empty. Pointers wrap: next write/read of 0x3C round-trips correctly.
- Full ch 0 with simultaneous write 0x99 and pop -> count stays 8, no overflow, 0x99 read out eighth.
- Empty ch 3 with simultaneous write 0x11 and pop -> count = 1, underflow[3] = 1, r_data = 0x11.
- Write packet 0x01, 0x02, 0x03 (last on 0x03) to ch 1 -> pkt_avail[1] goes to 1 on the 0x03 edge. Pop 3 -> r_last = 1 on third word, pkt_avail[1] = 0 after the pop.
- Ch 2 with 5 words and overflow set, assert flush[2] together with a write to ch 2 -> next cycle count = 0, empty[2] = 1, overflow[2] = 0, write discarded, other channels unchanged.
